dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (port 0, CPU) and the DMA/debug loader (port 1, DMA). It owns the memory-side address, write-enable, lock and write-data signals and returns registered read data to the winning requester. It uses round-robin arbitration with a bounded burst length, so neither port starves. It sits between the MEM stage / DMA engine and the data memory. The ABUS[28] I/O decode stays in the memory.

Parameters:
ADDR_BIT_WIDTH, 32, requester and memory address width
DATA_BIT_WIDTH, 32, data width
MAX_BURST, 4, max consecutive accesses by one owner while the other port waits (>=1)

Ports:
CLK  in  1  clock, all state updates on posedge
RESET_N  in  1  synchronous active-low reset
FLUSH  in  1  pipeline flush; aborts current grant
REQ0  in  1  CPU access pending
WE0  in  1  CPU write (1) / read (0)
ADDR0  in  ADDR_BIT_WIDTH  CPU byte address
WDATA0  in  DATA_BIT_WIDTH  CPU write data
GNT0  out  1  CPU owns memory this cycle
RVALID0  out  1  RDATA valid for CPU
REQ1, WE1, ADDR1, WDATA1, GNT1, RVALID1  same as port 0, for DMA
RDATA  out  DATA_BIT_WIDTH  registered read data (shared)
M_ABUS  out  ADDR_BIT_WIDTH  memory address
M_WDATA  out  DATA_BIT_WIDTH  memory write data (drive DBUS when M_WE)
M_RDATA  in  DATA_BIT_WIDTH  memory read data (DBUS when !M_WE)
M_WE  out  1  memory write enable
M_LOCK  out  1  memory commit qualifier

Behaviour:
- States: IDLE, OWN0, OWN1 (registered). GNT0 = (state==OWN0), GNT1 = (state==OWN1), both registered. Never both 1.
- Access cycle: any cycle with GNTx & REQx & RESET_N & !FLUSH. The requester holds REQx/WEx/ADDRx/WDATAx stable until its access cycle and may change them the cycle after.
- Memory side is combinational from the owner: M_ABUS=ADDRx, M_WDATA=WDATAx.
- M_LOCK = access cycle. M_WE = access cycle & WEx. A write commits at the end of the access cycle.
- In IDLE: M_ABUS=0, M_WDATA=0, M_WE=0, M_LOCK=0.
- Read: on a read access cycle, RDATA<=M_RDATA at that edge and RVALIDx=1 for exactly the following cycle. Read latency = 1 cycle after the access cycle. RDATA holds its value otherwise. RVALIDx=0 after writes.
- Burst counter CNT (width clog2(MAX_BURST)+1) counts accesses in the current tenure. It resets to 0 on every ownership change or IDLE entry.
- LAST register holds the last owner. Reset value LAST=1, so the CPU wins the first tie.
- Next state, evaluated each posedge in priority order:
  - RESET_N=0: IDLE, CNT=0, LAST=1, RDATA=0, RVALID0/1=0.
  - FLUSH=1: IDLE, CNT=0, no RVALID this edge. LAST is unchanged.
  - IDLE: both REQ -> OWN(!LAST). One REQ -> that owner. None -> IDLE.
  - OWNx with REQx=1: CNT<=CNT+1.
    - If REQy=1 and CNT+1>=MAX_BURST -> OWNy, CNT=0, LAST=x.
    - Otherwise stay OWNx (back-to-back, one access per cycle).
  - OWNx with REQx=0: REQy -> OWNy, else IDLE. CNT=0, LAST=x.
- Grant-to-idle cost: after its final access the owner drops REQ. The next granted cycle has no access (M_WE=0, M_LOCK=0), then ownership is released.
- Reset or FLUSH asserted mid-grant: M_WE and M_LOCK are forced to 0 in that same cycle, so no partial write and no RVALID. A requester whose grant is aborted keeps REQ and is re-arbitrated from IDLE.
- MAX_BURST=1 gives strict alternation under contention.

Test Plan:
- Reset: RESET_N=0 for 2 cycles with REQ0=REQ1=1 -> GNT0=GNT1=0, M_WE=0, RVALID0/1=0, RDATA=0. After release, GNT0=1 on the next cycle.
- CPU write/read: REQ0, WE0=1, ADDR0=0x10, WDATA0=0xDEADBEEF -> next cycle GNT0=1, M_WE=1, M_LOCK=1, M_ABUS=0x10. Then read 0x10 -> RDATA=0xDEADBEEF with RVALID0=1 one cycle after the read access cycle, RVALID1=0.
- Tie after reset: REQ0=REQ1=1 from cycle 0, each port doing one access -> CPU granted first, then DMA, then CPU. GNT never overlaps.
- Burst fairness (MAX_BURST=4): REQ0 held continuously, REQ1 raised during the first CPU grant -> exactly 4 consecutive CPU access cycles, then GNT1=1 the next cycle.
- FLUSH abort: FLUSH=1 during a CPU write access cycle to 0x20 (mem=0x0) -> M_WE=0, mem[0x20] stays 0x0, state IDLE next cycle, regranted once FLUSH=0.
- Release: owner drops REQ after its last access with the other port idle -> one granted idle cycle (M_LOCK=0), then GNT=0 (IDLE).

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-ported data memory between the pipeline MEM
//             stage (port 0, CPU) and the DMA/debug loader (port 1, DMA).
//             Round-robin arbitration with a bounded burst length; the owner
//             drives the memory address/data/write-enable/lock, and read data
//             comes back registered to the winning requester.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RESET_N              clock, synchronous active-low reset
//    FLUSH                     pipeline flush, aborts the current grant
//    REQx/WEx/ADDRx/WDATAx     requester x access (x=0 CPU, x=1 DMA)
//    GNTx                      requester x owns memory this cycle
//    RVALIDx                   RDATA is valid for requester x
//    RDATA                     registered read data (shared by both ports)
//    M_ABUS/M_WDATA/M_WE       memory address, write data, write enable
//    M_RDATA                   memory read data
//    M_LOCK                    memory commit qualifier (access cycle)
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int MAX_BURST      = 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      FLUSH,
  input  logic                      REQ0,
  input  logic                      WE0,
  input  logic [ADDR_BIT_WIDTH-1:0] ADDR0,
  input  logic [DATA_BIT_WIDTH-1:0] WDATA0,
  output logic                      GNT0,
  output logic                      RVALID0,
  input  logic                      REQ1,
  input  logic                      WE1,
  input  logic [ADDR_BIT_WIDTH-1:0] ADDR1,
  input  logic [DATA_BIT_WIDTH-1:0] WDATA1,
  output logic                      GNT1,
  output logic                      RVALID1,
  output logic [DATA_BIT_WIDTH-1:0] RDATA,
  output logic [ADDR_BIT_WIDTH-1:0] M_ABUS,
  output logic [DATA_BIT_WIDTH-1:0] M_WDATA,
  input  logic [DATA_BIT_WIDTH-1:0] M_RDATA,
  output logic                      M_WE,
  output logic                      M_LOCK
);

  localparam int                 c_CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [c_CNT_W:0]   c_MAX_EXT = (c_CNT_W + 1)'(MAX_BURST);
  localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_CNT_W-1:0]          w_cnt_nxt;
  logic [c_CNT_W-1:0]          w_cnt_sat;
  logic [c_CNT_W:0]            w_cnt_inc;
  logic                        w_burst_done;
  logic                        r_last;      // 0 = CPU owned last, 1 = DMA
  logic                        w_last_nxt;
  logic                        w_acc0;
  logic                        w_acc1;
  logic                        w_rd_acc;
  logic [DATA_BIT_WIDTH-1:0]   r_rdata;
  logic                        r_rvalid0;
  logic                        r_rvalid1;

  // Access cycle: owner requesting, and neither reset nor flush is aborting it.
  assign w_acc0   = (r_state == OWN0) & REQ0 & RESET_N & ~FLUSH;
  assign w_acc1   = (r_state == OWN1) & REQ1 & RESET_N & ~FLUSH;
  assign w_rd_acc = (w_acc0 & ~WE0) | (w_acc1 & ~WE1);

  // One extra bit so the increment cannot wrap when MAX_BURST is a power of
  // two boundary (e.g. MAX_BURST=1 gives a 1-bit counter).
  assign w_cnt_inc    = {1'b0, r_cnt} + (c_CNT_W + 1)'(1);
  assign w_burst_done = (w_cnt_inc >= c_MAX_EXT);
  // Saturate during uncontended tenures; the switch decision only needs to
  // know the burst limit has been reached.
  assign w_cnt_sat    = w_burst_done ? c_MAX : w_cnt_inc[c_CNT_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    if (FLUSH) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          if (REQ0 && REQ1) begin
            w_state_nxt = r_last ? OWN0 : OWN1;
          end else if (REQ0) begin
            w_state_nxt = OWN0;
          end else if (REQ1) begin
            w_state_nxt = OWN1;
          end
        end
        OWN0: begin
          if (REQ0) begin
            if (REQ1 && w_burst_done) begin
              w_state_nxt = OWN1;
              w_cnt_nxt   = '0;
              w_last_nxt  = 1'b0;
            end else begin
              w_cnt_nxt = w_cnt_sat;
            end
          end else begin
            w_state_nxt = REQ1 ? OWN1 : IDLE;
            w_cnt_nxt   = '0;
            w_last_nxt  = 1'b0;
          end
        end
        OWN1: begin
          if (REQ1) begin
            if (REQ0 && w_burst_done) begin
              w_state_nxt = OWN0;
              w_cnt_nxt   = '0;
              w_last_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_sat;
            end
          end else begin
            w_state_nxt = REQ0 ? OWN0 : IDLE;
            w_cnt_nxt   = '0;
            w_last_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      if (w_rd_acc) begin
        r_rdata <= M_RDATA;
      end
      r_rvalid0 <= w_acc0 & ~WE0;
      r_rvalid1 <= w_acc1 & ~WE1;
    end
  end

  // Memory side follows the owner combinationally; quiet when idle.
  always_comb begin
    M_ABUS  = '0;
    M_WDATA = '0;
    case (r_state)
      OWN0: begin
        M_ABUS  = ADDR0;
        M_WDATA = WDATA0;
      end
      OWN1: begin
        M_ABUS  = ADDR1;
        M_WDATA = WDATA1;
      end
      default: begin
        M_ABUS  = '0;
        M_WDATA = '0;
      end
    endcase
  end

  assign M_LOCK  = w_acc0 | w_acc1;
  assign M_WE    = (w_acc0 & WE0) | (w_acc1 & WE1);
  assign GNT0    = (r_state == OWN0);
  assign GNT1    = (r_state == OWN1);
  assign RVALID0 = r_rvalid0;
  assign RVALID1 = r_rvalid1;
  assign RDATA   = r_rdata;

endmodule
`default_nettype wire
